// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: mux select enums (one package per mux) and the
// rv32i_types package with the control word, immediate bundle and funct enums.
package pcmux;
  typedef enum logic [1:0] {pc_plus4, alu_out, alu_mod2} pcmux_sel_t;
endpackage

package marmux;
  typedef enum logic {pc_out, alu_out} marmux_sel_t;
endpackage

package cmpmux;
  typedef enum logic {rs2_out, i_imm} cmpmux_sel_t;
endpackage

package alumux;
  typedef enum logic {rs1_out, pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {i_imm, u_imm, b_imm, s_imm, j_imm, rs2_out} alumux2_sel_t;
endpackage

package regfilemux;
  typedef enum logic [3:0] {
    alu_out, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu
  } regfilemux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {sb = 3'b000, sh = 3'b001, sw = 3'b010} store_funct3_t;

  typedef enum logic [2:0] {
    add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
    axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
  } alu_ops;

  // Base byte enables for stores; MEM shifts them by the address low bits.
  typedef logic [3:0] store_be_t;
  localparam store_be_t SB_BE = 4'b0001;
  localparam store_be_t SH_BE = 4'b0011;
  localparam store_be_t SW_BE = 4'b1111;

  typedef struct packed {
    logic [6:0]                  opcode;
    logic [4:0]                  rd;
    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic [31:0]                 pc;
    alu_ops                      aluop;
    logic                        load_regfile;
    logic                        rmask;
    logic                        wmask;
    store_be_t                   mem_byte_enable;
    logic [1:0]                  mem_addr_bits;
    pcmux::pcmux_sel_t           pcmux_sel;
    marmux::marmux_sel_t         marmux_sel;
    cmpmux::cmpmux_sel_t         cmpmux_sel;
    alumux::alumux1_sel_t        alumux1_sel;
    alumux::alumux2_sel_t        alumux2_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
  } rv32i_control_word;

  typedef struct packed {
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
  } packed_imm;
endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus bundle for the decode stage.
interface decode_stage_if;
  import rv32i_types::*;

  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              id_ready;
  logic              flush;
  logic              ex_ready;
  logic              id_valid;
  rv32i_control_word ctrl;
  packed_imm         imm;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, id_valid, ctrl, imm, rs1, rs2, illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, id_valid, ctrl, imm, rs1, rs2, illegal
  );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Purely combinational RV32I decoder: instruction word + PC to control word,
// immediates and source register indices.
module instr_decoder
  import rv32i_types::*;
(
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  output rv32i_control_word ctrl,
  output packed_imm         imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              illegal
);
  logic [2:0] f3;
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  always_comb begin
    imm.i_imm = {{21{instr[31]}}, instr[30:20]};
    imm.s_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    imm.b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    imm.u_imm = {instr[31:12], 12'h000};
    imm.j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  always_comb begin
    ctrl        = '0;
    illegal     = 1'b0;
    ctrl.opcode = instr[6:0];
    ctrl.rd     = instr[11:7];
    ctrl.funct3 = f3;
    ctrl.funct7 = instr[31:25];
    ctrl.pc     = pc;
    case (instr[6:0])
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.alumux1_sel    = alumux::pc_out;
        ctrl.alumux2_sel    = alumux::u_imm;
        ctrl.aluop          = alu_add;
        ctrl.regfilemux_sel = regfilemux::alu_out;
      end
      op_jal: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.alumux1_sel    = alumux::pc_out;
        ctrl.alumux2_sel    = alumux::j_imm;
        ctrl.aluop          = alu_add;
        ctrl.pcmux_sel      = pcmux::alu_out;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_jalr: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.alumux1_sel    = alumux::rs1_out;
        ctrl.alumux2_sel    = alumux::i_imm;
        ctrl.aluop          = alu_add;
        ctrl.pcmux_sel      = pcmux::alu_mod2;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_br: begin
        // Taken/not-taken is resolved in EX from br_en.
        ctrl.cmpmux_sel  = cmpmux::rs2_out;
        ctrl.alumux1_sel = alumux::pc_out;
        ctrl.alumux2_sel = alumux::b_imm;
        ctrl.aluop       = alu_add;
        case (branch_funct3_t'(f3))
          beq, bne, blt, bge, bltu, bgeu: ;
          default: illegal = 1'b1;
        endcase
      end
      op_load: begin
        ctrl.alumux2_sel = alumux::i_imm;
        ctrl.aluop       = alu_add;
        ctrl.marmux_sel  = marmux::alu_out;
        case (load_funct3_t'(f3))
          lb:      ctrl.regfilemux_sel = regfilemux::lb;
          lh:      ctrl.regfilemux_sel = regfilemux::lh;
          lw:      ctrl.regfilemux_sel = regfilemux::lw;
          lbu:     ctrl.regfilemux_sel = regfilemux::lbu;
          lhu:     ctrl.regfilemux_sel = regfilemux::lhu;
          default: illegal = 1'b1;
        endcase
        ctrl.rmask        = !illegal;
        ctrl.load_regfile = !illegal;
      end
      op_store: begin
        ctrl.alumux2_sel = alumux::s_imm;
        ctrl.aluop       = alu_add;
        ctrl.marmux_sel  = marmux::alu_out;
        case (store_funct3_t'(f3))
          sb:      ctrl.mem_byte_enable = SB_BE;
          sh:      ctrl.mem_byte_enable = SH_BE;
          sw:      ctrl.mem_byte_enable = SW_BE;
          default: illegal = 1'b1;
        endcase
        ctrl.wmask = !illegal;
      end
      op_imm, op_reg: begin
        ctrl.load_regfile = 1'b1;
        if (instr[6:0] == op_reg) begin
          ctrl.alumux2_sel = alumux::rs2_out;
          ctrl.cmpmux_sel  = cmpmux::rs2_out;
        end else begin
          ctrl.alumux2_sel = alumux::i_imm;
          ctrl.cmpmux_sel  = cmpmux::i_imm;
        end
        case (arith_funct3_t'(f3))
          add: begin
            // bit30 is immediate data for addi, only a sub select for op_reg.
            if (instr[6:0] == op_reg && instr[30]) ctrl.aluop = alu_sub;
            else                                   ctrl.aluop = alu_add;
          end
          sr: begin
            if (instr[30]) ctrl.aluop = alu_sra;
            else           ctrl.aluop = alu_srl;
          end
          sll:       ctrl.aluop = alu_sll;
          axor:      ctrl.aluop = alu_xor;
          aor:       ctrl.aluop = alu_or;
          aand:      ctrl.aluop = alu_and;
          slt, sltu: ctrl.regfilemux_sel = regfilemux::br_en;
          default: ;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal || instr[11:7] == 5'd0) ctrl.load_regfile = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake from fetch, one output
// register toward EX with stall, drain and flush.
module decode_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);
  rv32i_control_word dec_ctrl, ctrl_d, ctrl_q;
  packed_imm         dec_imm, imm_d, imm_q;
  logic [4:0]        dec_rs1, dec_rs2, rs1_d, rs1_q, rs2_d, rs2_q;
  logic              dec_illegal, illegal_d, illegal_q;
  logic              valid_d, valid_q;
  logic              accept;

  instr_decoder u_dec (
    .instr   (bus.if_instr),
    .pc      (bus.if_pc),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .illegal (dec_illegal)
  );

  assign bus.id_ready = !valid_q || bus.ex_ready;
  assign accept       = bus.if_valid && bus.id_ready && !bus.flush;

  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    // Flush wins; otherwise accept refills, and a consumed slot with nothing
    // arriving drains to a bubble with all side-effect enables cleared.
    if (bus.flush || (!accept && bus.ex_ready)) begin
      valid_d             = 1'b0;
      illegal_d           = 1'b0;
      ctrl_d.load_regfile = 1'b0;
      ctrl_d.rmask        = 1'b0;
      ctrl_d.wmask        = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
      ctrl_d    = dec_ctrl;
      imm_d     = dec_imm;
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      ctrl_q.pc <= RESET_PC;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  assign bus.id_valid = valid_q;
  assign bus.illegal  = illegal_q;
  assign bus.ctrl     = ctrl_q;
  assign bus.imm      = imm_q;
  assign bus.rs1      = rs1_q;
  assign bus.rs2      = rs2_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, stall, flush, drain, reset and
// decode of a handful of hand-encoded RV32I instructions.
module tb_decode_stage;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  decode_stage_if bus ();

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic er);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.flush    = fl;
    bus.ex_ready = er;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_pc", bus.ctrl.pc, RST_PC);
    chk("rst_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    chk("rst_i_imm", bus.imm.i_imm, 32'd0);
    chk("rst_j_imm", bus.imm.j_imm, 32'd0);
    chk("rst_rs1", 32'(bus.rs1), 32'd0);
    chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
    rst = 1'b0;

    // addi x5,x1,-1
    drive(1'b1, 32'hFFF08293, 32'h100, 1'b0, 1'b1);
    tick();
    chk("addi_valid", 32'(bus.id_valid), 32'd1);
    chk("addi_aluop", 32'(bus.ctrl.aluop), 32'(alu_add));
    chk("addi_alumux2", 32'(bus.ctrl.alumux2_sel), 32'(alumux::i_imm));
    chk("addi_i_imm", bus.imm.i_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(bus.ctrl.rd), 32'd5);
    chk("addi_load_regfile", 32'(bus.ctrl.load_regfile), 32'd1);
    chk("addi_pc", bus.ctrl.pc, 32'h100);
    chk("addi_rs1", 32'(bus.rs1), 32'd1);

    // sub then sra back-to-back
    drive(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b1);
    tick();
    chk("sub_valid", 32'(bus.id_valid), 32'd1);
    chk("sub_aluop", 32'(bus.ctrl.aluop), 32'(alu_sub));
    chk("sub_rd", 32'(bus.ctrl.rd), 32'd3);
    chk("sub_rs2", 32'(bus.rs2), 32'd2);
    drive(1'b1, 32'h4020D1B3, 32'h108, 1'b0, 1'b1);
    tick();
    chk("sra_valid", 32'(bus.id_valid), 32'd1);
    chk("sra_aluop", 32'(bus.ctrl.aluop), 32'(alu_sra));
    chk("sra_pc", bus.ctrl.pc, 32'h108);

    // beq x1,x2,+8 then stall three cycles with changing fetch input
    drive(1'b1, 32'h00208463, 32'h10C, 1'b0, 1'b1);
    tick();
    chk("beq_b_imm", bus.imm.b_imm, 32'd8);
    chk("beq_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    chk("beq_alumux2", 32'(bus.ctrl.alumux2_sel), 32'(alumux::b_imm));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h402081B3 + 32'(i << 12), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      #1;
      chk("stall_id_ready", 32'(bus.id_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(bus.id_valid), 32'd1);
      chk("stall_pc", bus.ctrl.pc, 32'h10C);
      chk("stall_b_imm", bus.imm.b_imm, 32'd8);
      chk("stall_opcode", 32'(bus.ctrl.opcode), 32'h63);
    end

    // flush squashes held beq and the presented sw
    drive(1'b1, 32'h0020A023, 32'h300, 1'b1, 1'b0);
    tick();
    chk("flush_valid", 32'(bus.id_valid), 32'd0);
    chk("flush_wmask", 32'(bus.ctrl.wmask), 32'd0);
    chk("flush_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    drive(1'b0, 32'h0020A023, 32'h300, 1'b0, 1'b1);
    tick();
    chk("post_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("post_flush_wmask", 32'(bus.ctrl.wmask), 32'd0);

    // sh x2,4(x1)
    drive(1'b1, 32'h00209223, 32'h304, 1'b0, 1'b1);
    tick();
    chk("sh_wmask", 32'(bus.ctrl.wmask), 32'd1);
    chk("sh_be", 32'(bus.ctrl.mem_byte_enable), 32'h3);
    chk("sh_s_imm", bus.imm.s_imm, 32'd4);
    chk("sh_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    chk("sh_alumux2", 32'(bus.ctrl.alumux2_sel), 32'(alumux::s_imm));

    // lw x5,0(x1), then malformed load funct3=011
    drive(1'b1, 32'h0000A283, 32'h308, 1'b0, 1'b1);
    tick();
    chk("lw_rmask", 32'(bus.ctrl.rmask), 32'd1);
    chk("lw_regfilemux", 32'(bus.ctrl.regfilemux_sel), 32'(regfilemux::lw));
    chk("lw_load_regfile", 32'(bus.ctrl.load_regfile), 32'd1);
    drive(1'b1, 32'h0000B283, 32'h30C, 1'b0, 1'b1);
    tick();
    chk("badld_illegal", 32'(bus.illegal), 32'd1);
    chk("badld_rmask", 32'(bus.ctrl.rmask), 32'd0);
    chk("badld_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);

    // opcode 0x7F with rd=31, then addi x0,x0,0
    drive(1'b1, 32'h00000FFF, 32'h310, 1'b0, 1'b1);
    tick();
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    chk("ill_wmask", 32'(bus.ctrl.wmask), 32'd0);
    drive(1'b1, 32'h00000013, 32'h314, 1'b0, 1'b1);
    tick();
    chk("nop_illegal", 32'(bus.illegal), 32'd0);
    chk("nop_valid", 32'(bus.id_valid), 32'd1);
    chk("nop_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);

    // drain
    drive(1'b0, 32'h00000013, 32'h318, 1'b0, 1'b1);
    tick();
    chk("drain_valid", 32'(bus.id_valid), 32'd0);
    chk("drain_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);

    // reset mid-stall
    drive(1'b1, 32'hFFF08293, 32'h400, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("prerst_valid", 32'(bus.id_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.id_valid), 32'd0);
    chk("midrst_load_regfile", 32'(bus.ctrl.load_regfile), 32'd0);
    chk("midrst_pc", bus.ctrl.pc, RST_PC);
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
